conway_engine: RTL



---
 rtl/conway_engine.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/conway_engine.sv
// conway_engine: parametrised Game-of-Life board engine.
// Two ping-pong banks hold the board; STEP reads the current bank and writes
// the other one, then a one-cycle SWAP makes the new generation current.
// Optional feature macro: CONWAY_RULE_PROG_EN adds birth_mask/survive_mask
// ports for a programmable rule; without it the rule is fixed at B3/S23.
module conway_engine #(
    parameter int LOG_WIDTH  = 3,
    parameter int LOG_HEIGHT = 3,
    parameter bit WRAP       = 1'b1,
    parameter int GEN_WIDTH  = 16,
    localparam int AW        = LOG_WIDTH + LOG_HEIGHT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           cmd,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 rng_bit,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic                 wr_data,
`ifdef CONWAY_RULE_PROG_EN
    input  logic [8:0]           birth_mask,
    input  logic [8:0]           survive_mask,
`endif
    input  logic [AW-1:0]        rd_addr,
    output logic                 rd_data,
    output logic                 busy,
    output logic                 done,
    output logic [GEN_WIDTH-1:0] generation,
    output logic [AW:0]          population
);

    localparam int N = 1 << AW;

    localparam logic [1:0] CMD_CLEAR  = 2'd1;
    localparam logic [1:0] CMD_RANDOM = 2'd2;
    localparam logic [1:0] CMD_STEP   = 2'd3;

    localparam logic [AW-1:0]        IDX_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]          POP_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [GEN_WIDTH-1:0] GEN_ONE = {{(GEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LOG_WIDTH:0]   X_ONE   = {{LOG_WIDTH{1'b0}}, 1'b1};
    localparam logic [LOG_HEIGHT:0]  Y_ONE   = {{LOG_HEIGHT{1'b0}}, 1'b1};

    // Offset directions along one axis
    localparam logic [1:0] DIR_SAME  = 2'd0;
    localparam logic [1:0] DIR_PLUS  = 2'd1;
    localparam logic [1:0] DIR_MINUS = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RANDOM,
        S_STEP,
        S_SWAP
    } state_t;

    state_t state;

    logic              sel;
    logic [AW-1:0]     idx;
    logic [3:0]        sub;
    logic [3:0]        nbr;
    logic [AW:0]       acc;

    logic [N-1:0]      bank [2];
    logic [N-1:0]      cur_bank;

    logic [8:0]        birth_rule;
    logic [8:0]        survive_rule;

    logic [1:0]        dx_dir;
    logic [1:0]        dy_dir;
    logic [LOG_WIDTH:0]  nx;
    logic [LOG_HEIGHT:0] ny;
    logic [AW-1:0]     nb_addr;
    logic              nb_in_range;
    logic              nb_val;
    logic              cur_cell;
    logic              next_cell;
    logic              last_cell;

    logic              we;
    logic              we_bank;
    logic [AW-1:0]     waddr;
    logic              wdata;

`ifdef CONWAY_RULE_PROG_EN
    assign birth_rule   = birth_mask;
    assign survive_rule = survive_mask;
`else
    assign birth_rule   = 9'b000001000;
    assign survive_rule = 9'b000001100;
`endif

    assign cur_bank  = bank[sel];
    assign last_cell = &idx;

    // Pick the neighbour offset visited in the current sub-cycle
    always_comb begin
        dx_dir = DIR_SAME;
        dy_dir = DIR_SAME;
        case (sub[2:0])
            3'd0: begin dx_dir = DIR_MINUS; dy_dir = DIR_PLUS;  end
            3'd1: begin dx_dir = DIR_SAME;  dy_dir = DIR_PLUS;  end
            3'd2: begin dx_dir = DIR_PLUS;  dy_dir = DIR_PLUS;  end
            3'd3: begin dx_dir = DIR_MINUS; dy_dir = DIR_SAME;  end
            3'd4: begin dx_dir = DIR_PLUS;  dy_dir = DIR_SAME;  end
            3'd5: begin dx_dir = DIR_MINUS; dy_dir = DIR_MINUS; end
            3'd6: begin dx_dir = DIR_SAME;  dy_dir = DIR_MINUS; end
            3'd7: begin dx_dir = DIR_PLUS;  dy_dir = DIR_MINUS; end
            default: begin dx_dir = DIR_SAME; dy_dir = DIR_SAME; end
        endcase
    end

    // Neighbour coordinates carry one extra bit so that stepping off either
    // edge sets the top bit; the low bits are the wrapped coordinate
    always_comb begin
        nx = {1'b0, idx[LOG_WIDTH-1:0]};
        ny = {1'b0, idx[AW-1:LOG_WIDTH]};
        if (dx_dir == DIR_PLUS)  nx = nx + X_ONE;
        if (dx_dir == DIR_MINUS) nx = nx - X_ONE;
        if (dy_dir == DIR_PLUS)  ny = ny + Y_ONE;
        if (dy_dir == DIR_MINUS) ny = ny - Y_ONE;
        nb_addr     = {ny[LOG_HEIGHT-1:0], nx[LOG_WIDTH-1:0]};
        nb_in_range = WRAP || !(nx[LOG_WIDTH] || ny[LOG_HEIGHT]);
        nb_val      = cur_bank[nb_addr] && nb_in_range;
        cur_cell    = cur_bank[idx];
        next_cell   = cur_cell ? survive_rule[nbr] : birth_rule[nbr];
    end

    // Single bank write port shared by pokes, CLEAR, RANDOM and STEP
    always_comb begin
        we      = 1'b0;
        we_bank = sel;
        waddr   = idx;
        wdata   = 1'b0;
        if (!reset) begin
            case (state)
                S_IDLE: begin
                    we    = wr_en;
                    waddr = wr_addr;
                    wdata = wr_data;
                end
                S_CLEAR: begin
                    we    = 1'b1;
                    wdata = 1'b0;
                end
                S_RANDOM: begin
                    we    = 1'b1;
                    wdata = rng_bit;
                end
                S_STEP: begin
                    we      = (sub == 4'd8);
                    we_bank = ~sel;
                    wdata   = next_cell;
                end
                default: we = 1'b0;
            endcase
        end
    end

    // Board storage; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) bank[we_bank][waddr] <= wdata;
    end

    // Registered display read port from the current bank
    always_ff @(posedge clk) begin
        if (reset) rd_data <= 1'b0;
        else       rd_data <= cur_bank[rd_addr];
    end

    // Command sequencer with registered status outputs and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            sel        <= 1'b0;
            idx        <= '0;
            sub        <= 4'd0;
            nbr        <= 4'd0;
            acc        <= '0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            generation <= '0;
            population <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_en && (wr_data != cur_bank[wr_addr])) begin
                        population <= wr_data ? population + POP_ONE
                                              : population - POP_ONE;
                    end
                    if (cmd_valid && (cmd != 2'd0)) begin
                        idx       <= '0;
                        sub       <= 4'd0;
                        nbr       <= 4'd0;
                        acc       <= '0;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        case (cmd)
                            CMD_CLEAR:  state <= S_CLEAR;
                            CMD_RANDOM: state <= S_RANDOM;
                            CMD_STEP:   state <= S_STEP;
                            default:    state <= S_IDLE;
                        endcase
                    end
                end
                S_CLEAR: begin
                    idx <= idx + IDX_ONE;
                    if (last_cell) begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        cmd_ready  <= 1'b1;
                        done       <= 1'b1;
                        population <= '0;
                        generation <= '0;
                    end
                end
                S_RANDOM: begin
                    idx <= idx + IDX_ONE;
                    acc <= acc + {{AW{1'b0}}, rng_bit};
                    if (last_cell) begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        cmd_ready  <= 1'b1;
                        done       <= 1'b1;
                        population <= acc + {{AW{1'b0}}, rng_bit};
                        generation <= '0;
                    end
                end
                S_STEP: begin
                    if (sub == 4'd8) begin
                        sub <= 4'd0;
                        nbr <= 4'd0;
                        acc <= acc + {{AW{1'b0}}, next_cell};
                        idx <= idx + IDX_ONE;
                        if (last_cell) state <= S_SWAP;
                    end else begin
                        sub <= sub + 4'd1;
                        nbr <= nbr + {3'b000, nb_val};
                    end
                end
                S_SWAP: begin
                    sel        <= ~sel;
                    population <= acc;
                    generation <= generation + GEN_ONE;
                    state      <= S_IDLE;
                    busy       <= 1'b0;
                    cmd_ready  <= 1'b1;
                    done       <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
